delay_line_prog: RTL
====================

Name: delay_line_prog

Overview:
- Parametrised successor to the fixed single-bit delay line.
- Delays a WIDTH-bit input bus by a runtime-selectable number of enabled clock cycles, from 1 to MAX_DEPTH.
- Provides stall (en), synchronous flush and an output-valid flag that tracks pipeline fill.
- Sits in the MEMORY group as the general building block for retiming and latency matching in later circuits.

Parameters:
- WIDTH, 8: data bits per stage.
- MAX_DEPTH, 8: number of register stages, which is also the maximum delay; must be >= 2.
- SEL_W, 3: width of delay_sel; must satisfy 2^SEL_W >= MAX_DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  advance enable; when 0 the line holds its contents.
- flush  input  1  synchronous clear of contents and fill state.
- delay_sel  input  SEL_W  requested delay minus 1.
- in0  input  WIDTH  data in.
- out  output  WIDTH  delayed data.
- out_valid  output  1  out holds data written since the last reset or flush.
- fill  output  SEL_W+1  number of valid stages, 0..MAX_DEPTH.

Behaviour:
- Storage is stage[0..MAX_DEPTH-1], each WIDTH bits, plus fill counter fill_q.
- Reset (rst_n=0, asynchronous): all stages = 0, fill_q = 0.
  - Therefore out = 0, out_valid = 0 and fill = 0 during reset and immediately after release.
- Effective delay: d = min(delay_sel+1, MAX_DEPTH). An out-of-range delay_sel clamps to MAX_DEPTH.
- out = stage[d-1], combinational from registers; no extra register on the output.
  - Result: with en held 1, out at edge t+d equals in0 sampled at edge t, an exact latency of d cycles.
- out_valid = (fill_q >= d), combinational.
- Per rising edge, with priority flush > en:
  - flush=1: all stages = 0, fill_q = 0. This applies regardless of en, and the in0 value on that edge is discarded.
  - en=1: stage[0] <= in0; stage[i] <= stage[i-1]; fill_q <= min(fill_q+1, MAX_DEPTH), saturating.
  - en=0: all state holds, so out and out_valid hold unless delay_sel changes.
- Changing delay_sel takes effect in the same cycle, since only the tap mux changes.
  - Increasing d may drop out_valid if fill_q < new d.
  - Decreasing d exposes more recent data immediately.
  - No data is lost, because stage contents are independent of delay_sel.
- Boundaries:
  - fill_q saturates at MAX_DEPTH and never wraps.
  - d = 1 behaves as a plain register.
  - d = MAX_DEPTH taps the last stage.
  - Reset asserted mid-stream clears everything asynchronously; the first valid output after release appears d enabled edges later.
- No combinational path from in0 to out.

Decomposition:
- Package delay_pkg holds:
  - localparam defaults DEF_WIDTH = 8 and DEF_DEPTH = 8.
  - function eff_delay(sel, max_depth), implementing the clamp rule, shared with the bench model.
- One natural sub-module, delay_stage: a WIDTH-bit register with async active-low reset, synchronous clear and enable.
  - The top instantiates MAX_DEPTH delay_stage instances via generate.
  - The top also contains the fill counter and the tap mux.

Test Plan:
- Latency sweep:
  - Stimulus: WIDTH=8, MAX_DEPTH=8, en=1, in0 = cycle count 1,2,3,... For each delay_sel 0..7, reset then drive.
  - Required: first out_valid=1 exactly d edges after release, with out = 1 at that point and then incrementing each cycle.
- Stall:
  - Stimulus: delay_sel=2; feed 0x11, 0x22, 0x33, 0x44; hold en=0 for 3 cycles, then resume with 0x55.
  - Required: out and fill frozen during the stall; the output sequence is 0x11, 0x22, 0x33, 0x44, 0x55 with no duplicates or gaps counted in enabled cycles.
- Flush priority:
  - Stimulus: pipeline full (fill=8); assert flush=1 with en=1 and in0=0xAA for one edge.
  - Required: fill=0, out=0, out_valid=0 next cycle; 0xAA never appears on out.
- Dynamic delay change:
  - Stimulus: after 8 cycles of in0 = 1..8 with delay_sel=1, switch to delay_sel=5 and hold en=0.
  - Required: out jumps from 7 to 3 with no clock edge.
  - Then, after flush and 2 writes, set delay_sel=5.
  - Required: out_valid=0 while fill=2 < 6, and out_valid=1 once fill reaches 6.
- Clamp and saturation:
  - Stimulus: SEL_W=4, MAX_DEPTH=8, delay_sel=15.
  - Required: d=8 (last stage tapped); after 20 enabled cycles fill stays at 8.
- Async reset mid-operation:
  - Stimulus: drop rst_n between clock edges while the line is full.
  - Required: out=0, out_valid=0 and fill=0 immediately, without waiting for clk; normal fill restarts after release.

Source files
------------

// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared defaults and delay clamp helper for the programmable delay line
//
// Purpose: default geometry and the effective-delay rule, shared by the
//          delay line and anything that needs to predict its latency.
// Ports:   none (package).

package delay_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Requested delay is sel+1 cycles; anything past the physical depth
  // taps the last stage.
  function automatic int eff_delay(input int sel, input int max_depth);
    if (sel + 1 > max_depth) begin
      return max_depth;
    end
    return sel + 1;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// rtl/delay_stage.sv - one WIDTH-bit register stage with clear and enable
//
// Purpose: single storage stage of the delay line.
// Ports:   clk    rising-edge clock
//          rst_n  asynchronous active-low reset (q -> 0)
//          clr    synchronous clear, wins over en
//          en     load d on the rising edge
//          d      stage input
//          q      stage contents

module delay_stage
  import delay_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/delay_line_prog.sv
// rtl/delay_line_prog.sv - WIDTH-bit delay line with runtime-selectable depth
//
// Purpose: delays in0 by d = min(delay_sel+1, MAX_DEPTH) enabled cycles.
// Ports:   clk        rising-edge clock
//          rst_n      asynchronous active-low reset
//          en         advance enable; 0 holds all state
//          flush      synchronous clear of stages and fill count (beats en)
//          delay_sel  requested delay minus 1
//          in0        data in
//          out        stage[d-1], combinational from registers
//          out_valid  fill count has reached the selected delay
//          fill       number of valid stages, 0..MAX_DEPTH

module delay_line_prog
  import delay_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_DEPTH = DEF_DEPTH,
  parameter int SEL_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [SEL_W-1:0] delay_sel,
  input  logic [WIDTH-1:0] in0,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [SEL_W:0]   fill
);

  localparam logic [SEL_W:0] FILL_MAX = (SEL_W+1)'(MAX_DEPTH);
  localparam logic [SEL_W:0] FILL_ONE = (SEL_W+1)'(1);

  logic [WIDTH-1:0] stage_q [MAX_DEPTH];
  logic [SEL_W:0]   fill_q;
  logic [SEL_W:0]   tap_d;

  for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (en),
        .d     (in0),
        .q     (stage_q[gi])
      );
    end else begin : g_tail
      delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (en),
        .d     (stage_q[gi-1]),
        .q     (stage_q[gi])
      );
    end
  end

  // Saturating count of stages holding post-reset/post-flush data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else if (flush) begin
      fill_q <= '0;
    end else if (en && (fill_q != FILL_MAX)) begin
      fill_q <= fill_q + FILL_ONE;
    end
  end

  // Tap mux: only this changes with delay_sel, so stage contents never
  // depend on the selected delay.
  always_comb begin
    tap_d = (SEL_W+1)'(eff_delay(int'(delay_sel), MAX_DEPTH));
    out   = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (tap_d == (SEL_W+1)'(i + 1)) begin
        out = stage_q[i];
      end
    end
  end

  assign out_valid = (fill_q >= tap_d);
  assign fill      = fill_q;

endmodule
